mem_stage: RTL and testbench

Memory stage of the five-stage MIPS pipeline. Registers the execute-stage result bundle `M_pre`, drives the data bus for loads and stores through a request/response handshake, aligns and extends load data, owns the HI/LO registers, and emits the writeback bundle `W_pre`. While a bus access is outstanding it raises a stall request that freezes the upstream pipeline.

---
 rtl/mem_stage_pkg.sv | 37 +++
 rtl/mem_align.sv | 31 +++
 rtl/mem_stage.sv | 79 +++++++
 tb/tb_mem_stage.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared pipeline types, bus size codes and access helpers for the memory stage.
package mem_stage_pkg;
  localparam logic [1:0] MSIZE1 = 2'd0;
  localparam logic [1:0] MSIZE2 = 2'd1;
  localparam logic [1:0] MSIZE4 = 2'd2;
  typedef enum logic [3:0] {
    OP_NOP, OP_ALU, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW,
    OP_SB, OP_SH, OP_SW, OP_MULT, OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO
  } op_t;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} mem_state_t;
  typedef struct packed {
    op_t         OP;
    logic [4:0]  regw;
    logic [31:0] pc;
    logic [31:0] valA;
    logic [31:0] valB;
    logic        rm;
    logic        wm;
    logic        hi_r;
    logic        hi_w;
    logic        lo_r;
    logic        lo_w;
  } M_type;
  typedef struct packed {
    op_t         OP;
    logic [4:0]  regw;
    logic [31:0] pc;
    logic [31:0] valA;
  } W_type;
  function automatic logic [1:0] msize(op_t op);
    return (op == OP_LB || op == OP_LBU || op == OP_SB) ? MSIZE1 :
           (op == OP_LH || op == OP_LHU || op == OP_SH) ? MSIZE2 : MSIZE4;
  endfunction
  function automatic logic misaligned(op_t op, logic [1:0] a);
    return msize(op) == MSIZE2 ? a[0] : msize(op) == MSIZE4 ? (a != 2'd0) : 1'b0;
  endfunction
endpackage

// File: rtl/mem_align.sv
// mem_align: store lane steering/replication and load lane extraction with sign/zero extension.
module mem_align
  import mem_stage_pkg::*;
(
  input  op_t         op,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  strobe,
  output logic [31:0] sdata,
  output logic [31:0] ldata
);
  logic [31:0] sh;
  logic [7:0]  b;
  logic [15:0] h;
  logic [1:0]  size;
  always_comb begin
    size   = msize(op);
    sh     = rdata >> {off, 3'b000};
    b      = sh[7:0];
    h      = off[1] ? rdata[31:16] : rdata[15:0];
    strobe = op == OP_SB ? 4'b0001 << off :
             op == OP_SH ? (off[1] ? 4'b1100 : 4'b0011) :
             op == OP_SW ? 4'b1111 : 4'b0000;
    sdata  = size == MSIZE1 ? {4{wdata[7:0]}} : size == MSIZE2 ? {2{wdata[15:0]}} : wdata;
    ldata  = op == OP_LB  ? {{24{b[7]}}, b} :
             op == OP_LBU ? {24'b0, b} :
             op == OP_LH  ? {{16{h[15]}}, h} :
             op == OP_LHU ? {16'b0, h} : rdata;
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: MIPS memory stage - M register, data-bus handshake FSM, HI/LO and writeback bundle.
// Define MEM_ALIGN_CHECK_EN to flag misaligned half/word accesses instead of issuing them.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  M_type       M_pre,
  input  logic        en,
  output logic        dreq_valid,
  output logic [31:0] dreq_addr,
  output logic [1:0]  dreq_size,
  output logic [3:0]  dreq_strobe,
  output logic [31:0] dreq_data,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  input  logic [31:0] dresp_data,
  output logic        busy,
  output W_type       W_pre,
  output logic [31:0] hi,
  output logic [31:0] lo
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic        addr_err
`endif
);
  M_type       m;
  mem_state_t  state, next;
  logic [31:0] rdata_q, ldata;
  logic        pre_mem, pre_mis, mis;
  assign pre_mem = M_pre.rm | M_pre.wm;
`ifdef MEM_ALIGN_CHECK_EN
  assign pre_mis  = pre_mem & misaligned(M_pre.OP, M_pre.valA[1:0]);
  assign mis      = (m.rm | m.wm) & misaligned(m.OP, m.valA[1:0]);
  assign addr_err = mis;
`else
  assign pre_mis = 1'b0;
  assign mis     = 1'b0;
`endif
  mem_align u_align (
    .op     (m.OP),
    .off    (m.valA[1:0]),
    .wdata  (m.valB),
    .rdata  (rdata_q),
    .strobe (dreq_strobe),
    .sdata  (dreq_data),
    .ldata  (ldata)
  );
  always_comb begin
    next = en ? (pre_mem ? (pre_mis ? S_DONE : S_ISSUE) : S_IDLE) :
           state == S_ISSUE ? (dresp_addr_ok ? (dresp_data_ok ? S_DONE : S_WAIT) : S_ISSUE) :
           state == S_WAIT  ? (dresp_data_ok ? S_DONE : S_WAIT) : state;
    dreq_valid   = state == S_ISSUE;
    busy         = state == S_ISSUE || state == S_WAIT;
    dreq_addr    = m.valA;
    dreq_size    = msize(m.OP);
    W_pre.OP     = m.OP;
    W_pre.pc     = m.pc;
    W_pre.regw   = ((m.rm && state != S_DONE) || mis) ? 5'd0 : m.regw;
    W_pre.valA   = m.rm ? ldata : m.hi_r ? hi : m.lo_r ? lo : m.valA;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m       <= '0;
      state   <= S_IDLE;
      hi      <= '0;
      lo      <= '0;
      rdata_q <= '0;
    end else begin
      state <= next;
      if (busy && next == S_DONE) rdata_q <= dresp_data;
      if (en) begin
        m <= M_pre;
        if (m.hi_w) hi <= m.valA;
        if (m.lo_w) lo <= m.hi_w ? m.valB : m.valA;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage with an inline bus responder.
module tb_mem_stage;
  import mem_stage_pkg::*;
  logic        clk = 1'b0, resetn = 1'b0, en = 1'b0;
  logic        dresp_addr_ok = 1'b0, dresp_data_ok = 1'b0;
  logic [31:0] dresp_data = '0;
  M_type       M_pre = '0;
  logic        dreq_valid, busy;
  logic [31:0] dreq_addr, dreq_data, hi, lo;
  logic [1:0]  dreq_size;
  logic [3:0]  dreq_strobe;
  W_type       W_pre;
`ifdef MEM_ALIGN_CHECK_EN
  logic        addr_err;
`endif
  mem_stage dut (
    .clk(clk), .resetn(resetn), .M_pre(M_pre), .en(en),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .busy(busy), .W_pre(W_pre), .hi(hi), .lo(lo)
`ifdef MEM_ALIGN_CHECK_EN
    , .addr_err(addr_err)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (resetn && busy) assert (!en) else $error("FAIL early_en: en asserted while busy");
  typedef struct {logic [31:0] va; logic [4:0] rw; logic [31:0] pc;} exp_t;
  exp_t        sb[$];
  int          n_tests = 0, n_fail = 0;
  logic [31:0] pc_ctr = 32'h0040_0000;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  function automatic M_type mk(op_t op, logic [4:0] rw, logic [31:0] a, logic [31:0] b);
    M_type x = '0;
    x.OP   = op;
    x.regw = rw;
    x.valA = a;
    x.valB = b;
    x.rm   = op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
    x.wm   = op inside {OP_SB, OP_SH, OP_SW};
    return x;
  endfunction
  task automatic run(input M_type x, input int waits, input logic [31:0] rd,
                     input logic [31:0] exp_va, input logic [4:0] exp_rw, input int exp_busy,
                     input logic [3:0] exp_strb, input logic [31:0] exp_wd);
    int   cyc;
    exp_t e;
    x.pc = pc_ctr;
    pc_ctr += 4;
    sb.push_back('{exp_va, exp_rw, x.pc});
    M_pre = x;
    en = 1'b1;
    step;
    en = 1'b0;
    cyc = 0;
    while (busy && cyc < 40) begin
      if (cyc == 0) begin
        chk("req_valid", {31'b0, dreq_valid}, 32'd1);
        chk("req_addr", dreq_addr, x.valA);
        chk("req_strobe", {28'b0, dreq_strobe}, {28'b0, exp_strb});
        if (x.wm) chk("req_data", dreq_data, exp_wd);
        if (x.rm) chk("regw_pending", {27'b0, W_pre.regw}, 32'd0);
      end
      dresp_addr_ok = cyc == 0;
      dresp_data_ok = cyc == waits;
      dresp_data    = rd;
      step;
      cyc++;
    end
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    chk("busy_cycles", cyc, exp_busy);
    e = sb.pop_front();
    chk("wb_valA", W_pre.valA, e.va);
    chk("wb_regw", {27'b0, W_pre.regw}, {27'b0, e.rw});
    chk("wb_pc", W_pre.pc, e.pc);
  endtask
  initial begin
    M_type x;
    step;
    step;
    chk("rst_valid", {31'b0, dreq_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_regw", {27'b0, W_pre.regw}, 32'd0);
    chk("rst_valA", W_pre.valA, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    resetn = 1'b1;
    step;
    run(mk(OP_ALU, 5'd5, 32'h1234_5678, 32'h0), 0, 32'h0, 32'h1234_5678, 5'd5, 0, 4'b0000, 32'h0);
    run(mk(OP_SW, 5'd0, 32'h100, 32'hDEAD_BEEF), 0, 32'h0, 32'h100, 5'd0, 1, 4'b1111, 32'hDEAD_BEEF);
    run(mk(OP_LB, 5'd8, 32'h103, 32'h0), 3, 32'h80FF_0000, 32'hFFFF_FF80, 5'd8, 4, 4'b0000, 32'h0);
    run(mk(OP_LHU, 5'd9, 32'h102, 32'h0), 1, 32'h8001_1234, 32'h0000_8001, 5'd9, 2, 4'b0000, 32'h0);
    run(mk(OP_SH, 5'd0, 32'h102, 32'h1234_ABCD), 0, 32'h0, 32'h102, 5'd0, 1, 4'b1100, 32'hABCD_ABCD);
    run(mk(OP_SB, 5'd0, 32'h101, 32'h0000_00A5), 2, 32'h0, 32'h101, 5'd0, 3, 4'b0010, 32'hA5A5_A5A5);
    run(mk(OP_LH, 5'd4, 32'h100, 32'h0), 2, 32'h0000_8123, 32'hFFFF_8123, 5'd4, 3, 4'b0000, 32'h0);
    run(mk(OP_LW, 5'd3, 32'h104, 32'h0), 0, 32'hCAFE_F00D, 32'hCAFE_F00D, 5'd3, 1, 4'b0000, 32'h0);
    dresp_data    = 32'h1111_1111;
    dresp_data_ok = 1'b1;
    step;
    dresp_data_ok = 1'b0;
    chk("stray_done_valA", W_pre.valA, 32'hCAFE_F00D);
    chk("stray_done_busy", {31'b0, busy}, 32'd0);
    x = mk(OP_MULT, 5'd0, 32'h1, 32'h2);
    x.hi_w = 1'b1;
    x.lo_w = 1'b1;
    run(x, 0, 32'h0, 32'h1, 5'd0, 0, 4'b0000, 32'h0);
    x = mk(OP_MFHI, 5'd10, 32'h0, 32'h0);
    x.hi_r = 1'b1;
    run(x, 0, 32'h0, 32'h1, 5'd10, 0, 4'b0000, 32'h0);
    x = mk(OP_MFLO, 5'd11, 32'h0, 32'h0);
    x.lo_r = 1'b1;
    run(x, 0, 32'h0, 32'h2, 5'd11, 0, 4'b0000, 32'h0);
    chk("hi_after_mult", hi, 32'h1);
    chk("lo_after_mult", lo, 32'h2);
    M_pre = mk(OP_LW, 5'd7, 32'h200, 32'h0);
    en = 1'b1;
    step;
    en = 1'b0;
    dresp_addr_ok = 1'b1;
    step;
    dresp_addr_ok = 1'b0;
    chk("wait_busy", {31'b0, busy}, 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("midrst_valid", {31'b0, dreq_valid}, 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    dresp_data    = 32'h5555_5555;
    dresp_data_ok = 1'b1;
    step;
    resetn = 1'b1;
    step;
    dresp_data_ok = 1'b0;
    chk("postrst_busy", {31'b0, busy}, 32'd0);
    chk("postrst_regw", {27'b0, W_pre.regw}, 32'd0);
    chk("postrst_valA", W_pre.valA, 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
    M_pre = mk(OP_LW, 5'd6, 32'h102, 32'h0);
    en = 1'b1;
    step;
    en = 1'b0;
    chk("mis_valid", {31'b0, dreq_valid}, 32'd0);
    chk("mis_err", {31'b0, addr_err}, 32'd1);
    chk("mis_busy", {31'b0, busy}, 32'd0);
    chk("mis_regw", {27'b0, W_pre.regw}, 32'd0);
    run(mk(OP_ALU, 5'd2, 32'h77, 32'h0), 0, 32'h0, 32'h77, 5'd2, 0, 4'b0000, 32'h0);
    chk("mis_err_clear", {31'b0, addr_err}, 32'd0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
